// File: rtl/sad_min_search.sv
// -----------------------------------------------------------------------------
// sad_min_search
//   Finds the minimum full-block SAD (and its candidate index) over a search of
//   NUM_BATCHES batches, each delivering PIXELS_IN_BATCH candidates as EDGE_LEN
//   column PSADs apiece. Three-stage datapath:
//     stage 1: per-candidate SAD = sum of its column PSADs
//     stage 2: batch minimum across lanes (lowest lane wins ties)
//     stage 3: running best (first batch loads, later ones replace on strict <)
//   done_o pulses 3 cycles after the last batch is accepted.
//
// Ports
//   clk_i              : clock, rising edge
//   rst_n_i            : asynchronous active-low reset
//   start_i            : begin a new search (honoured in IDLE or DONE)
//   psad_valid_i       : psad_addend_batch holds a batch this cycle
//   psad_addend_batch  : candidate k, column c at [(k*EDGE_LEN+c)*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]
//   busy_o             : search in progress (ACC or DRAIN)
//   done_o             : one-cycle pulse, result is final
//   best_sad_o         : minimum SAD found
//   best_idx_o         : candidate index of the minimum
// -----------------------------------------------------------------------------
module sad_min_search #(
    parameter int PIXELS_IN_BATCH = 16,
    parameter int EDGE_LEN        = 8,
    parameter int PSAD_BIT_WIDTH  = 11,
    parameter int SAD_BIT_WIDTH   = 14,
    parameter int NUM_BATCHES     = 16,
    localparam int IDX_W          = $clog2(NUM_BATCHES * PIXELS_IN_BATCH)
) (
    input  logic                                                clk_i,
    input  logic                                                rst_n_i,
    input  logic                                                start_i,
    input  logic                                                psad_valid_i,
    input  logic [PSAD_BIT_WIDTH*EDGE_LEN*PIXELS_IN_BATCH-1:0]  psad_addend_batch,
    output logic                                                busy_o,
    output logic                                                done_o,
    output logic [SAD_BIT_WIDTH-1:0]                            best_sad_o,
    output logic [IDX_W-1:0]                                    best_idx_o
);

    localparam int CNT_W  = (NUM_BATCHES > 1) ? $clog2(NUM_BATCHES) : 1;
    localparam int LANE_W = (PIXELS_IN_BATCH > 1) ? $clog2(PIXELS_IN_BATCH) : 1;
    localparam int CAND_W = PSAD_BIT_WIDTH * EDGE_LEN;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACC   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Unsigned sum of one candidate's column PSADs; the widest possible sum
    // fits SAD_BIT_WIDTH, so no saturation is needed.
    function automatic logic [SAD_BIT_WIDTH-1:0] cand_sad(input logic [CAND_W-1:0] cols);
        logic [SAD_BIT_WIDTH-1:0] acc;
        acc = '0;
        for (int c = 0; c < EDGE_LEN; c++) begin
            acc = acc + SAD_BIT_WIDTH'(cols[c*PSAD_BIT_WIDTH +: PSAD_BIT_WIDTH]);
        end
        return acc;
    endfunction

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_busy;
    logic                     w_done;
    logic [CNT_W-1:0]         r_bcnt;
    logic                     w_accept;
    logic                     w_start_go;
    logic                     w_last_batch;

    logic [SAD_BIT_WIDTH-1:0] r_sad_p1 [PIXELS_IN_BATCH];
    logic [CNT_W-1:0]         r_bcnt_p1;
    logic                     r_first_p1;
    logic                     r_vld_p1;

    logic [SAD_BIT_WIDTH-1:0] w_min_sad;
    logic [LANE_W-1:0]        w_min_lane;
    logic [IDX_W-1:0]         w_min_idx;

    logic [SAD_BIT_WIDTH-1:0] r_sad_p2;
    logic [IDX_W-1:0]         r_idx_p2;
    logic                     r_first_p2;
    logic                     r_vld_p2;

    logic [SAD_BIT_WIDTH-1:0] r_best_sad;
    logic [IDX_W-1:0]         r_best_idx;

    assign w_accept     = (r_state == S_ACC) && psad_valid_i;
    assign w_start_go   = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last_batch = (r_bcnt == CNT_W'(NUM_BATCHES - 1));

    // ---------------- control FSM ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) w_state_nxt = S_ACC;
            end
            S_ACC: begin
                w_busy = 1'b1;
                if (w_accept && w_last_batch) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_busy = 1'b1;
                // Once stage 1 is empty, the only remaining work is the
                // stage-3 update happening on this edge.
                if (!r_vld_p1) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = start_i ? S_ACC : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign busy_o = w_busy;
    assign done_o = w_done;

    // Batch counter saturates at the last batch; the FSM leaves ACC there.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_bcnt <= '0;
        end else if (w_start_go) begin
            r_bcnt <= '0;
        end else if (w_accept && !w_last_batch) begin
            r_bcnt <= r_bcnt + 1'b1;
        end
    end

    // ---------------- stage 1: candidate SADs ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < PIXELS_IN_BATCH; k++) r_sad_p1[k] <= '0;
            r_bcnt_p1  <= '0;
            r_first_p1 <= 1'b0;
            r_vld_p1   <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                for (int k = 0; k < PIXELS_IN_BATCH; k++) begin
                    r_sad_p1[k] <= cand_sad(psad_addend_batch[k*CAND_W +: CAND_W]);
                end
                r_bcnt_p1  <= r_bcnt;
                r_first_p1 <= (r_bcnt == '0);
            end
        end
    end

    // ---------------- stage 2: batch minimum ----------------
    always_comb begin
        w_min_sad  = r_sad_p1[0];
        w_min_lane = '0;
        for (int k = 1; k < PIXELS_IN_BATCH; k++) begin
            // Strict compare keeps the lowest lane on ties.
            if (r_sad_p1[k] < w_min_sad) begin
                w_min_sad  = r_sad_p1[k];
                w_min_lane = LANE_W'(k);
            end
        end
        w_min_idx = IDX_W'(r_bcnt_p1) * IDX_W'(PIXELS_IN_BATCH) + IDX_W'(w_min_lane);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sad_p2   <= '0;
            r_idx_p2   <= '0;
            r_first_p2 <= 1'b0;
            r_vld_p2   <= 1'b0;
        end else begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_sad_p2   <= w_min_sad;
                r_idx_p2   <= w_min_idx;
                r_first_p2 <= r_first_p1;
            end
        end
    end

    // ---------------- stage 3: running best ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_best_sad <= '0;
            r_best_idx <= '0;
        end else if (r_vld_p2 && (r_first_p2 || (r_sad_p2 < r_best_sad))) begin
            r_best_sad <= r_sad_p2;
            r_best_idx <= r_idx_p2;
        end
    end

    assign best_sad_o = r_best_sad;
    assign best_idx_o = r_best_idx;

endmodule

// File: tb/tb_sad_min_search.sv
module tb_sad_min_search;

    localparam int PIB   = 16;
    localparam int EL    = 8;
    localparam int PW    = 11;
    localparam int SW    = 14;
    localparam int NB    = 16;
    localparam int IDX_W = 8;
    localparam int BW    = PW * EL * PIB;

    logic             clk_i;
    logic             rst_n_i;
    logic             start_i;
    logic             psad_valid_i;
    logic [BW-1:0]    psad_addend_batch;
    logic             busy_o;
    logic             done_o;
    logic [SW-1:0]    best_sad_o;
    logic [IDX_W-1:0] best_idx_o;

    sad_min_search #(
        .PIXELS_IN_BATCH(PIB),
        .EDGE_LEN       (EL),
        .PSAD_BIT_WIDTH (PW),
        .SAD_BIT_WIDTH  (SW),
        .NUM_BATCHES    (NB)
    ) dut (
        .clk_i            (clk_i),
        .rst_n_i          (rst_n_i),
        .start_i          (start_i),
        .psad_valid_i     (psad_valid_i),
        .psad_addend_batch(psad_addend_batch),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .best_sad_o       (best_sad_o),
        .best_idx_o       (best_idx_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        int sad;
        int idx;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Hand-computed results per scenario:
    // 0 uniform PSAD=1 -> 8*1, idx 0
    // 1 lane5/batch3 zero, rest 100 -> 0, idx 3*16+5=53
    // 2 lane2/batch1 and lane0/batch4 PSAD 5 (SAD 40), rest 100 -> 40, idx 1*16+2=18
    // 3 all 2047 -> 8*2047=16376, idx 0
    int exp_sad [4] = '{8, 0, 40, 16376};
    int exp_idx [4] = '{0, 53, 18, 0};

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_n_i && done_o) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done_o=1 expected no pulse (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("done_cycle", cyc, e.cyc);
                chk("best_sad", int'(best_sad_o), e.sad);
                chk("best_idx", int'(best_idx_o), e.idx);
            end
        end
    end

    function automatic int psad_val(input int scen, input int b, input int k);
        case (scen)
            0: return 1;
            1: return (b == 3 && k == 5) ? 0 : 100;
            2: return ((b == 1 && k == 2) || (b == 4 && k == 0)) ? 5 : 100;
            3: return 2047;
            default: return 0;
        endcase
    endfunction

    function automatic logic [BW-1:0] mk_batch(input int scen, input int b);
        logic [BW-1:0] v;
        v = '0;
        for (int k = 0; k < PIB; k++)
            for (int c = 0; c < EL; c++)
                v[(k*EL+c)*PW +: PW] = PW'(psad_val(scen, b, k));
        return v;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Feeds nb batches; with gap set, each batch is followed by an idle cycle
    // carrying a stray start_i. Expectation is queued only for full searches.
    task automatic feed(input int scen, input bit gap, input int nb);
        int lc;
        lc = 0;
        for (int b = 0; b < nb; b++) begin
            psad_valid_i      = 1'b1;
            psad_addend_batch = mk_batch(scen, b);
            if (gap) chk("busy_valid", int'(busy_o), 1);
            lc = cyc;
            tick();
            if (gap) begin
                psad_valid_i      = 1'b0;
                psad_addend_batch = mk_batch(4, 0);
                start_i           = 1'b1;
                chk("busy_gap", int'(busy_o), 1);
                tick();
                start_i = 1'b0;
            end
        end
        psad_valid_i = 1'b0;
        if (nb == NB) begin
            exp_t e;
            e.sad = exp_sad[scen];
            e.idx = exp_idx[scen];
            e.cyc = lc + 3;
            q.push_back(e);
        end
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            tick();
            n++;
        end
        while (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL done_timeout: got no done_o expected pulse at cycle %0d", e.cyc);
        end
        tick();
    endtask

    initial begin
        rst_n_i           = 1'b0;
        start_i           = 1'b0;
        psad_valid_i      = 1'b0;
        psad_addend_batch = '0;
        tick();
        tick();
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_sad", int'(best_sad_o), 0);
        chk("rst_idx", int'(best_idx_o), 0);
        rst_n_i = 1'b1;

        // valid while idle must be ignored
        psad_valid_i      = 1'b1;
        psad_addend_batch = mk_batch(4, 0);
        tick();
        tick();
        psad_valid_i = 1'b0;
        chk("idle_busy", int'(busy_o), 0);

        // uniform batches
        do_start();
        chk("busy_acc", int'(busy_o), 1);
        feed(0, 1'b0, NB);
        wait_idle();
        repeat (3) tick();
        chk("hold_sad", int'(best_sad_o), 8);

        // unique minimum, then restart straight from DONE into the tie case
        do_start();
        feed(1, 1'b0, NB);
        tick();
        tick();
        chk("done_busy", int'(busy_o), 0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("restart_busy", int'(busy_o), 1);
        feed(2, 1'b0, NB);
        wait_idle();

        // all-max PSADs with valid gaps and stray start pulses
        do_start();
        feed(3, 1'b1, NB);
        wait_idle();

        // reset mid-search after 7 batches of all-zero data
        do_start();
        feed(4, 1'b0, 7);
        #2 rst_n_i = 1'b0;
        #1;
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_sad", int'(best_sad_o), 0);
        tick();
        rst_n_i = 1'b1;
        repeat (6) tick();
        chk("post_rst_busy", int'(busy_o), 0);
        do_start();
        feed(2, 1'b0, NB);
        wait_idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
